// File: rtl/mil_tx_arbiter_pkg.sv
// Shared types and defaults for the two-requester MIL transmit arbiter.
// Word layout, FSM encoding and the owner index helpers live here.
package mil_tx_arbiter_pkg;

    localparam int WORD_W             = 16;
    localparam int N_REQ              = 2;
    localparam int GAP_CYCLES_DEF     = 600;
    localparam int TIMEOUT_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // One requester's offered word as seen by the mux.
    typedef struct packed {
        logic [WORD_W-1:0] dat;
        logic              cmd;
        logic              last;
    } word_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [N_REQ-1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mil_tx_arbiter_rr_picker.sv
// Purpose: two-way round-robin chooser; on a tie the requester that did not own last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is actually latched.
module mil_tx_arbiter_rr_picker
    import mil_tx_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last_owner,
    output logic [N_REQ-1:0] win
);

    logic win_idx;

    always_comb begin
        win_idx = 1'b0;
        win     = '0;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_owner;
            default: win_idx = 1'b0;
        endcase
        if (|req) begin
            win = owner_onehot(win_idx);
        end
    end

endmodule

// File: rtl/mil_tx_arbiter.sv
// Purpose: grants one of two requesters the transmitter for a whole packet, then enforces a bus turnaround gap.
// Latency: grant one cycle after the IDLE decision; words pass through combinationally with zero latency.
// Backpressure: outReady feeds the owner's inReady directly; owner starvation aborts after TIMEOUT_CYCLES.
module mil_tx_arbiter
    import mil_tx_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic [N_REQ-1:0]        inValid,
    input  logic [N_REQ*WORD_W-1:0] inData,
    input  logic [N_REQ-1:0]        inCmd,
    input  logic [N_REQ-1:0]        inLast,
    output logic [N_REQ-1:0]        inReady,
    output logic                    outValid,
    output logic [WORD_W-1:0]       outData,
    output logic                    outCmd,
    input  logic                    outReady,
    input  logic                    rxBusy,
    input  logic                    txBusy,
    output logic [N_REQ-1:0]        grant,
    output logic                    abort
);

    localparam int CNT_MAX = max_int(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             rx_busy_q, rx_busy_d;

    logic [N_REQ-1:0] pick_win;
    word_t            req_word [N_REQ];
    word_t            own_word;
    logic             own_vld;
    logic             rx_rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    mil_tx_arbiter_rr_picker u_picker (
        .req        (inValid),
        .last_owner (owner_q),
        .win        (pick_win)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_word[i] = '{dat: inData[i*WORD_W +: WORD_W], cmd: inCmd[i], last: inLast[i]};
        end
    end

    assign own_word = req_word[owner_q];
    assign own_vld  = inValid[owner_q];
    // Only an edge ends the gap early: a receiver already busy when the gap starts does not cut it short.
    assign rx_rise  = rxBusy && !rx_busy_q;
    assign abort    = abort_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        rx_busy_d = rxBusy;
        outValid  = 1'b0;
        outData   = '0;
        outCmd    = 1'b0;
        inReady   = '0;
        grant     = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if ((|pick_win) && !rxBusy && !txBusy) begin
                    owner_d = pick_win[1];
                    state_d = ST_PASS;
                end
            end

            ST_PASS: begin
                outValid         = own_vld;
                outData          = own_word.dat;
                outCmd           = own_word.cmd;
                inReady[owner_q] = outReady;
                grant            = owner_onehot(owner_q);
                if (own_vld && outReady) begin
                    cnt_d = '0;
                    if (own_word.last) begin
                        state_d = ST_GAP;
                    end
                end else if (!own_vld) begin
                    // Transmitter back-pressure holds the count; only an idle owner advances it.
                    if (cnt_q >= TO_LAST) begin
                        abort_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end

            ST_GAP: begin
                if (rx_rise || (cnt_q >= GAP_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b1;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            rx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            rx_busy_q <= rx_busy_d;
        end
    end

endmodule

// File: tb/tb_mil_tx_arbiter.sv
// Scoreboarded bench for mil_tx_arbiter: directed scenarios plus randomized request rounds,
// with expected transmitter words predicted from the round-robin / packet-ownership rules.
module tb_mil_tx_arbiter;

    localparam int GAP = 600;
    localparam int TO  = 1000;

    logic        clk = 1'b0;
    logic        nRst;
    logic        vld0, vld1, cmd0, cmd1, last0, last1;
    logic [15:0] dat0, dat1;
    logic [1:0]  in_valid, in_cmd, in_last, in_ready, grant;
    logic [31:0] in_data;
    logic        out_valid, out_cmd, out_ready, rx_busy, tx_busy, abort;
    logic [15:0] out_data;

    assign in_valid = {vld1, vld0};
    assign in_cmd   = {cmd1, cmd0};
    assign in_last  = {last1, last0};
    assign in_data  = {dat1, dat0};

    always #5 clk = ~clk;

    mil_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .inValid  (in_valid),
        .inData   (in_data),
        .inCmd    (in_cmd),
        .inLast   (in_last),
        .inReady  (in_ready),
        .outValid (out_valid),
        .outData  (out_data),
        .outCmd   (out_cmd),
        .outReady (out_ready),
        .rxBusy   (rx_busy),
        .txBusy   (tx_busy),
        .grant    (grant),
        .abort    (abort)
    );

    typedef struct { logic [15:0] dat; logic cmd; logic last; int pre; } drv_word_t;
    typedef struct { logic [15:0] dat; logic cmd; int who; } exp_word_t;

    drv_word_t q0[$];
    drv_word_t q1[$];
    exp_word_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   aborts_seen = 0;
    bit   abort_allowed = 1'b0;
    int   last_owner_m = 1;
    bit   rdy_rand = 1'b0;
    logic rdy_val = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester drivers: each word waits 'pre' idle cycles, then stays valid until accepted.
    initial begin : driver
        logic [1:0] acc;
        int idle0, idle1;
        bit ld0, ld1;
        idle0 = 0; idle1 = 0; ld0 = 1'b0; ld1 = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0; cmd0 = 1'b0; cmd1 = 1'b0;
        last0 = 1'b0; last1 = 1'b0; dat0 = '0; dat1 = '0; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() > 0) begin void'(q0.pop_front()); ld0 = 1'b0; end
            if (q0.size() == 0) begin
                ld0 = 1'b0; vld0 = 1'b0;
            end else begin
                if (!ld0) begin idle0 = q0[0].pre; ld0 = 1'b1; end
                if (idle0 > 0) begin vld0 = 1'b0; idle0--; end
                else begin vld0 = 1'b1; dat0 = q0[0].dat; cmd0 = q0[0].cmd; last0 = q0[0].last; end
            end
            if (acc[1] && q1.size() > 0) begin void'(q1.pop_front()); ld1 = 1'b0; end
            if (q1.size() == 0) begin
                ld1 = 1'b0; vld1 = 1'b0;
            end else begin
                if (!ld1) begin idle1 = q1[0].pre; ld1 = 1'b1; end
                if (idle1 > 0) begin vld1 = 1'b0; idle1--; end
                else begin vld1 = 1'b1; dat1 = q1[0].dat; cmd1 = q1[0].cmd; last1 = q1[0].last; end
            end
            out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_val;
        end
    end

    initial begin : monitor
        exp_word_t e;
        forever begin
            @(negedge clk);
            if (abort) begin
                aborts_seen++;
                if (!abort_allowed) chk("unexpected_abort", 32'(abort), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %h, none expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e.dat));
                    chk("word_cmd", 32'(out_cmd), 32'(e.cmd));
                    chk("word_grant", 32'(grant), 32'(1 << e.who));
                    chk("word_inready", 32'(in_ready), 32'(1 << e.who));
                end
            end
        end
    end

    task automatic count_while(input logic [1:0] val, input int limit, output int n);
        n = 0;
        while (grant == val && n <= limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_grant(input int limit);
        int n = 0;
        while (grant == 2'b00 && n < limit) begin @(negedge clk); n++; end
        if (grant == 2'b00) begin
            checks++; errors++;
            $display("FAIL grant_timeout: no grant after %0d cycles", limit);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d words pending after %0d cycles", exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    task automatic push_word(input int who, input logic [15:0] d, input logic c, input logic l,
                             input int pre, input bit expect_it);
        drv_word_t w;
        w = '{dat: d, cmd: c, last: l, pre: pre};
        if (who == 0) q0.push_back(w); else q1.push_back(w);
        if (expect_it) exp_q.push_back('{dat: d, cmd: c, who: who});
    endtask

    // One arbitration round: all chosen requesters raise their first word on the same cycle.
    task automatic run_round(input logic [1:0] who, input bit rnd_pre, input int tx_hold);
        drv_word_t p[2][$];
        drv_word_t w;
        int len, first, second;
        for (int r = 0; r < 2; r++) begin
            if (who[r]) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    w.dat  = 16'($urandom);
                    w.cmd  = (k == 0) ? 1'b1 : 1'($urandom_range(1));
                    w.last = (k == len - 1);
                    w.pre  = (k == 0 || !rnd_pre) ? 0 : $urandom_range(3);
                    p[r].push_back(w);
                end
            end
        end
        if (who == 2'b11) first = (last_owner_m == 0) ? 1 : 0;
        else              first = who[1] ? 1 : 0;
        second = 1 - first;
        foreach (p[first][k]) exp_q.push_back('{dat: p[first][k].dat, cmd: p[first][k].cmd, who: first});
        if (who == 2'b11) begin
            foreach (p[second][k]) exp_q.push_back('{dat: p[second][k].dat, cmd: p[second][k].cmd, who: second});
            last_owner_m = second;
        end else begin
            last_owner_m = first;
        end
        tx_busy = (tx_hold > 0);
        foreach (p[0][k]) q0.push_back(p[0][k]);
        foreach (p[1][k]) q1.push_back(p[1][k]);
        if (tx_hold > 0) begin
            repeat (tx_hold) @(negedge clk);
            chk("txbusy_blocks_grant", 32'(grant), 32'd0);
            tx_busy = 1'b0;
        end
        wait_drain(20000);
        repeat (GAP + 5) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, ab;
        nRst = 1'b0; rx_busy = 1'b0; tx_busy = 1'b0;

        // Three-word packet queued during reset; outputs must stay low while held.
        push_word(0, 16'h1234, 1'b1, 1'b0, 0, 1'b1);
        push_word(0, 16'hAAAA, 1'b0, 1'b0, 0, 1'b1);
        push_word(0, 16'h5555, 1'b0, 1'b1, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_outvalid", 32'(out_valid), 32'd0);
        chk("reset_inready", 32'(in_ready), 32'd0);
        chk("reset_abort", 32'(abort), 32'd0);
        chk("reset_outdata", 32'(out_data), 32'd0);
        nRst = 1'b1;
        @(negedge clk);
        count_while(2'b01, 20, n);
        chk("pkt3_grant_cycles", 32'(n), 32'd3);
        // Second requester waits through the gap plus the IDLE latch cycle.
        push_word(1, 16'hBEEF, 1'b1, 1'b1, 0, 1'b1);
        last_owner_m = 1;
        count_while(2'b00, 2000, n);
        chk("gap_to_next_grant", 32'(n), 32'(GAP + 1));
        wait_drain(100);
        repeat (GAP + 5) @(negedge clk);

        // Simultaneous requests after reset, then round-robin alternation.
        nRst = 1'b0; last_owner_m = 1;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        run_round(2'b11, 1'b0, 0);
        run_round(2'b11, 1'b0, 0);
        run_round(2'b01, 1'b0, 0);
        run_round(2'b11, 1'b0, 0);

        // Owner stalls after its first word until the timeout aborts the packet.
        abort_allowed = 1'b1; ab = aborts_seen;
        push_word(0, 16'h0F0F, 1'b1, 1'b0, 0, 1'b1);
        push_word(0, 16'hDEAD, 1'b0, 1'b1, 5000, 1'b0);
        last_owner_m = 0;
        wait_grant(20);
        count_while(2'b01, TO + 50, n);
        chk("timeout_grant_cycles", 32'(n), 32'(TO + 1));
        chk("abort_pulse_high", 32'(abort), 32'd1);
        chk("grant_after_abort", 32'(grant), 32'd0);
        q0.delete();
        @(negedge clk);
        chk("abort_pulse_low", 32'(abort), 32'd0);
        repeat (GAP + 5) @(negedge clk);
        chk("abort_count", 32'(aborts_seen - ab), 32'd1);
        abort_allowed = 1'b0;

        // Long transmitter back-pressure is not a stall.
        rdy_val = 1'b0; ab = aborts_seen;
        push_word(0, 16'hC0DE, 1'b0, 1'b1, 0, 1'b1);
        last_owner_m = 0;
        wait_grant(20);
        repeat (2000) @(negedge clk);
        chk("bp_outvalid", 32'(out_valid), 32'd1);
        chk("bp_grant", 32'(grant), 32'd1);
        chk("bp_no_abort", 32'(aborts_seen - ab), 32'd0);
        rdy_val = 1'b1;
        wait_drain(20);
        repeat (GAP + 5) @(negedge clk);

        // Receiver busy blocks the grant; a receiver edge during the gap ends it early.
        rx_busy = 1'b1;
        push_word(0, 16'h7777, 1'b1, 1'b1, 0, 1'b1);
        last_owner_m = 0;
        repeat (50) @(negedge clk);
        chk("rx_blocks_grant", 32'(grant), 32'd0);
        rx_busy = 1'b0;
        @(negedge clk);
        chk("rx_release_grant", 32'(grant), 32'd1);
        repeat (10) @(negedge clk);
        push_word(1, 16'h8888, 1'b1, 1'b1, 0, 1'b1);
        last_owner_m = 1;
        rx_busy = 1'b1;
        repeat (3) @(negedge clk);
        rx_busy = 1'b0;
        count_while(2'b00, 2000, n);
        chk("rx_gap_exit", 32'(n), 32'd1);
        wait_drain(50);
        repeat (GAP + 5) @(negedge clk);

        // Reset in the middle of a packet.
        ab = aborts_seen;
        push_word(0, 16'h1111, 1'b1, 1'b0, 0, 1'b1);
        push_word(0, 16'h2222, 1'b0, 1'b0, 50, 1'b0);
        push_word(0, 16'h3333, 1'b0, 1'b1, 0, 1'b0);
        wait_drain(50);
        repeat (5) @(negedge clk);
        chk("midpkt_grant", 32'(grant), 32'd1);
        chk("midpkt_inready", 32'(in_ready), 32'd1);
        nRst = 1'b0;
        #1;
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_outvalid", 32'(out_valid), 32'd0);
        chk("rst_mid_inready", 32'(in_ready), 32'd0);
        q0.delete();
        repeat (5) @(negedge clk);
        chk("rst_mid_no_abort", 32'(aborts_seen - ab), 32'd0);
        nRst = 1'b1;
        last_owner_m = 1;
        run_round(2'b11, 1'b0, 0);

        // Randomized rounds: random requester sets, lengths, idle gaps, tx busy and back-pressure.
        rdy_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            run_round(2'($urandom_range(1, 3)), 1'b1, $urandom_range(0, 3));
        end
        rdy_rand = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
